// File: rtl/cache_pkg.sv
// ============================================================================
//  Module   : cache_pkg
//  Purpose  : Shared geometry, FSM state type and address helpers for the
//             l1_cache_ctrl controller and its tag/data array.
//  Ports    : none (package)
//  Options  : none here; the top honours the L1_STATS_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

   localparam int ADDR_W  = 11;
   localparam int DATA_W  = 8;
   localparam int LINES   = 16;
   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = ADDR_W - INDEX_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      L2_REQ = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Line index is the low address bits.
   function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
      return INDEX_W'(addr);
   endfunction

   // Tag is everything above the index.
   function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
      return TAG_W'(addr >> INDEX_W);
   endfunction

endpackage

`default_nettype wire

// File: rtl/l1_tag_data_array.sv
// ============================================================================
//  Module   : l1_tag_data_array
//  Purpose  : Per-line valid bit, tag and data storage for a direct-mapped
//             cache. Combinational read, synchronous write; rst clears only
//             the valid bits.
//  Ports    : clk, rst          - clock, synchronous active-high clear of valids
//             rd_idx            - read line select
//             rd_valid/tag/data - contents of the selected line
//             wr_idx            - write line select
//             data_we, wr_data  - update data of an already-resident line
//             fill_we, wr_tag   - install line: data, tag and valid together
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_tag_data_array
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rd_idx,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [DATA_W-1:0]  rd_data,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic               data_we,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic               fill_we,
   input  logic [TAG_W-1:0]   wr_tag
);

   logic [LINES-1:0] valid_vec;
   logic [TAG_W-1:0]  tag_vec  [LINES];
   logic [DATA_W-1:0] data_vec [LINES];

   for (genvar i = 0; i < LINES; i++) begin : g_line
      logic              sel;
      logic              valid_q, valid_d;
      logic [TAG_W-1:0]  tag_q,   tag_d;
      logic [DATA_W-1:0] data_q,  data_d;

      assign sel = (wr_idx == INDEX_W'(i));

      always_comb begin
         valid_d = valid_q;
         tag_d   = tag_q;
         data_d  = data_q;
         if (sel && fill_we) begin
            valid_d = 1'b1;
            tag_d   = wr_tag;
         end
         if (sel && (fill_we || data_we)) begin
            data_d = wr_data;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= valid_d;
         end
      end

      // Tag and data carry no reset; a cleared valid bit masks them.
      always_ff @(posedge clk) begin
         tag_q  <= tag_d;
         data_q <= data_d;
      end

      assign valid_vec[i] = valid_q;
      assign tag_vec[i]   = tag_q;
      assign data_vec[i]  = data_q;
   end

   assign rd_valid = valid_vec[rd_idx];
   assign rd_tag   = tag_vec[rd_idx];
   assign rd_data  = data_vec[rd_idx];

endmodule

`default_nettype wire

// File: rtl/l1_cache_ctrl.sv
// ============================================================================
//  Module   : l1_cache_ctrl
//  Purpose  : Direct-mapped, write-through, no-write-allocate L1 controller.
//             One CPU request at a time; read misses fill from L2, all writes
//             are forwarded to L2 over a req/ack handshake.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             ivalid/iRW/iaddress/iwrite_data - CPU request (iRW=1 read)
//             oready, odone            - accept strobe / one-cycle completion
//             oread_data               - read result, holds after odone
//             oL1miss, oL2miss         - miss status, valid through odone
//             ol2_req/we/addr/wdata    - L2 request, held until il2_ack
//             il2_ack/rdata/miss       - L2 completion, fill data, miss flag
//             ohit_count/omiss_count   - read hit/miss counters (L1_STATS_EN)
//  Options  : `define L1_STATS_EN adds saturating 16-bit read statistics.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_cache_ctrl
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ivalid,
   input  logic              iRW,
   input  logic [ADDR_W-1:0] iaddress,
   input  logic [DATA_W-1:0] iwrite_data,
   output logic              oready,
   output logic              odone,
   output logic [DATA_W-1:0] oread_data,
   output logic              oL1miss,
   output logic              oL2miss,
   output logic              ol2_req,
   output logic              ol2_we,
   output logic [ADDR_W-1:0] ol2_addr,
   output logic [DATA_W-1:0] ol2_wdata,
   input  logic              il2_ack,
   input  logic [DATA_W-1:0] il2_rdata,
   input  logic              il2_miss
`ifdef L1_STATS_EN
   ,
   output logic [15:0]       ohit_count,
   output logic [15:0]       omiss_count
`endif
);

   state_t              state_q,  state_d;
   logic [ADDR_W-1:0]   addr_q,   addr_d;
   logic                rw_q,     rw_d;
   logic [DATA_W-1:0]   wdata_q,  wdata_d;
   logic [DATA_W-1:0]   rdata_q,  rdata_d;
   logic                l1miss_q, l1miss_d;
   logic                l2miss_q, l2miss_d;
   logic                l2we_q,   l2we_d;

   logic                arr_valid;
   logic [TAG_W-1:0]    arr_tag;
   logic [DATA_W-1:0]   arr_rdata;
   logic                arr_data_we;
   logic                arr_fill_we;
   logic [DATA_W-1:0]   arr_wdata;
   logic                hit;

   assign hit = arr_valid && (arr_tag == get_tag(addr_q));

   l1_tag_data_array u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (get_index(addr_q)),
      .rd_valid (arr_valid),
      .rd_tag   (arr_tag),
      .rd_data  (arr_rdata),
      .wr_idx   (get_index(addr_q)),
      // A reset edge must never install or modify a line.
      .data_we  (arr_data_we && !rst),
      .wr_data  (arr_wdata),
      .fill_we  (arr_fill_we && !rst),
      .wr_tag   (get_tag(addr_q))
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rw_d        = rw_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      l1miss_d    = l1miss_q;
      l2miss_d    = l2miss_q;
      l2we_d      = l2we_q;
      arr_data_we = 1'b0;
      arr_fill_we = 1'b0;
      arr_wdata   = wdata_q;

      case (state_q)
         IDLE: begin
            if (ivalid && oready) begin
               addr_d  = iaddress;
               rw_d    = iRW;
               wdata_d = iwrite_data;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (rw_q) begin
               if (hit) begin
                  rdata_d = arr_rdata;
                  state_d = RESP;
               end else begin
                  l1miss_d = 1'b1;
                  l2we_d   = 1'b0;
                  state_d  = L2_REQ;
               end
            end else begin
               // Write-through: always forwarded; only a resident line is updated.
               arr_data_we = hit;
               l1miss_d    = !hit;
               l2we_d      = 1'b1;
               state_d     = L2_REQ;
            end
         end
         L2_REQ: begin
            if (il2_ack) begin
               l2miss_d = il2_miss;
               if (!l2we_q) begin
                  arr_fill_we = 1'b1;
                  arr_wdata   = il2_rdata;
                  rdata_d     = il2_rdata;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            l1miss_d = 1'b0;
            l2miss_d = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rw_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         l1miss_q <= 1'b0;
         l2miss_q <= 1'b0;
         l2we_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rw_q     <= rw_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         l1miss_q <= l1miss_d;
         l2miss_q <= l2miss_d;
         l2we_q   <= l2we_d;
      end
   end

   assign oready     = (state_q == IDLE) && !rst;
   assign odone      = (state_q == RESP);
   assign oread_data = rdata_q;
   assign oL1miss    = l1miss_q;
   assign oL2miss    = l2miss_q;
   // Request and its fields come straight from state/latched registers, so
   // they stay stable until the ack edge moves the FSM to RESP.
   assign ol2_req    = (state_q == L2_REQ);
   assign ol2_we     = l2we_q;
   assign ol2_addr   = addr_q;
   assign ol2_wdata  = wdata_q;

`ifdef L1_STATS_EN
   logic [15:0] hit_cnt_q,  hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if ((state_q == LOOKUP) && rw_q) begin
         if (hit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
         end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign ohit_count  = hit_cnt_q;
   assign omiss_count = miss_cnt_q;
`endif

endmodule

`default_nettype wire
